// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, bus-mode constants
// and the helper used to size the phase counter.
package spi_master_pkg;

  localparam int   SPI_DATA_W = 16;
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_sclk_div.sv
// Phase counter for the SPI master: loaded with (length-1) on each state entry,
// counts down while enabled and flags the last cycle of the phase.
module spi_master_sclk_div #(
  parameter int PH_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [PH_W-1:0] load_val,
  output logic            phase_end
);

  logic [PH_W-1:0] cnt_r;

  // Down-counter; parks at zero so it never wraps inside a phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - PH_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign phase_end = en && (cnt_r == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex MSB-first frame per accepted start pulse,
// with programmable sclk half-period and cs setup/hold times.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int HALF_DIV = 5,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_trans,
  input  logic              miso,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_recv
);

  localparam int PH_W = $clog2(max3(HALF_DIV, CS_SETUP, CS_HOLD));
  localparam int BC_W = $clog2(DATA_W + 1);

  spi_state_e        state_r, state_nxt_s;
  logic [DATA_W-1:0] tx_sr_r, rx_sr_r;
  logic [BC_W-1:0]   bit_cnt_r;
  logic              load_s, en_s, phase_end_s;
  logic [PH_W-1:0]   load_val_s;

  spi_master_sclk_div #(.PH_W(PH_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .en        (en_s),
    .load_val  (load_val_s),
    .phase_end (phase_end_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every transition reloads the phase counter with its new length.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_val_s  = '0;
    en_s        = (state_r != ST_IDLE) && (state_r != ST_DONE);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SETUP;
          load_s      = 1'b1;
          load_val_s  = PH_W'(CS_SETUP - 1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP, ST_HIGH: begin
        if (phase_end_s) begin
          state_nxt_s = (state_r == ST_SETUP) ? ST_HIGH : ST_LOW;
          load_s      = 1'b1;
          load_val_s  = PH_W'(HALF_DIV - 1);
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOW: begin
        if (phase_end_s && (bit_cnt_r == BC_W'(DATA_W))) begin
          state_nxt_s = ST_HOLD;
          load_s      = 1'b1;
          load_val_s  = PH_W'(CS_HOLD - 1);
        end else if (phase_end_s) begin
          state_nxt_s = ST_HIGH;
          load_s      = 1'b1;
          load_val_s  = PH_W'(HALF_DIV - 1);
        end else begin
          state_nxt_s = ST_LOW;
        end
      end
      ST_HOLD: begin
        if (phase_end_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered bus outputs, shift registers and bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs        <= 1'b1;
      sclk      <= SPI_CPOL;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_recv <= '0;
      tx_sr_r   <= '0;
      rx_sr_r   <= '0;
      bit_cnt_r <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            tx_sr_r   <= data_trans;
            cs        <= 1'b0;
            mosi      <= data_trans[DATA_W-1];
            busy      <= 1'b1;
            bit_cnt_r <= '0;
          end
        end
        ST_SETUP: begin
          if (phase_end_s) begin
            sclk <= 1'b1;
          end
        end
        ST_HIGH: begin
          // miso is taken just before the fall so the slave has the whole high phase to settle.
          if (phase_end_s) begin
            sclk      <= 1'b0;
            rx_sr_r   <= {rx_sr_r[DATA_W-2:0], miso};
            bit_cnt_r <= bit_cnt_r + BC_W'(1);
            if (bit_cnt_r != BC_W'(DATA_W - 1)) begin
              mosi    <= tx_sr_r[DATA_W-2];
              tx_sr_r <= tx_sr_r << 1;
            end
          end
        end
        ST_LOW: begin
          if (phase_end_s && (bit_cnt_r != BC_W'(DATA_W))) begin
            sclk <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_end_s) begin
            cs        <= 1'b1;
            data_recv <= rx_sr_r;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
